// File: rtl/softmax_norm.sv
// Softmax normalisation: buffers NUM_CLASSES exp values, sums them, then emits
// value/sum for each class in arrival order using a bit-serial restoring divider.
module softmax_norm #(
    parameter int  DATA_WIDTH  = 32,
    parameter int  FRACTION    = 24,
    parameter int  NUM_CLASSES = 10,
    localparam int IDX_WIDTH   = $clog2(NUM_CLASSES),
    localparam int SUM_WIDTH   = DATA_WIDTH + IDX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  softmax_ready_in,
    input  logic                  softmax_valid_in,
    input  logic [DATA_WIDTH-1:0] softmax_data_in,
    input  logic                  softmax_ready_out,
    output logic                  softmax_valid_out,
    output logic [DATA_WIDTH-1:0] softmax_data_out,
    output logic [IDX_WIDTH-1:0]  softmax_index_out,
    output logic                  softmax_last_out
);

    localparam int BCNT_W = $clog2(FRACTION + 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {COLLECT, DIVIDE, EMIT} state_e;

    state_e                  state_q, state_d;
    logic [IDX_WIDTH-1:0]    cnt_q, cnt_d;
    logic [SUM_WIDTH-1:0]    sum_q, sum_d;
    logic [SUM_WIDTH-1:0]    rem_q, rem_d;
    logic [FRACTION-1:0]     quo_q, quo_d;
    logic                    nbit_q, nbit_d;
    logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
    logic                    run_q, run_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [IDX_WIDTH-1:0]    idx_q, idx_d;
    logic                    last_q, last_d;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_q [NUM_CLASSES];

    logic [SUM_WIDTH:0]      trial;
    logic                    ge;
    logic [SUM_WIDTH-1:0]    rem_step;
    logic [FRACTION:0]       quo_step;

    // Dividend is value<<FRACTION: its top part (value>>1) seeds the remainder,
    // value[0] is the first bit shifted in, all later bits are zero.
    assign trial    = {rem_q, nbit_q};
    assign ge       = trial >= {1'b0, sum_q};
    assign rem_step = ge ? (trial[SUM_WIDTH-1:0] - sum_q) : trial[SUM_WIDTH-1:0];
    assign quo_step = {quo_q, ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        nbit_d  = nbit_q;
        bcnt_d  = bcnt_q;
        run_d   = run_q;
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        mem_we  = 1'b0;
        case (state_q)
            COLLECT: begin
                if (softmax_valid_in) begin
                    mem_we = 1'b1;
                    sum_d  = sum_q + SUM_WIDTH'(softmax_data_in);
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        run_d   = 1'b0;
                        state_d = DIVIDE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DIVIDE: begin
                if (!run_q) begin
                    run_d  = 1'b1;
                    rem_d  = SUM_WIDTH'(mem_q[cnt_q] >> 1);
                    nbit_d = mem_q[cnt_q][0];
                    bcnt_d = BCNT_W'(FRACTION);
                    quo_d  = '0;
                end else if (sum_q == '0 || bcnt_q == '0) begin
                    data_d  = (sum_q == '0) ? '0 : DATA_WIDTH'(quo_step);
                    valid_d = 1'b1;
                    idx_d   = cnt_q;
                    last_d  = (cnt_q == LAST_IDX);
                    run_d   = 1'b0;
                    state_d = EMIT;
                end else begin
                    rem_d  = rem_step;
                    quo_d  = quo_step[FRACTION-1:0];
                    nbit_d = 1'b0;
                    bcnt_d = bcnt_q - 1'b1;
                end
            end
            EMIT: begin
                if (softmax_ready_out) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        sum_d   = '0;
                        cnt_d   = '0;
                        state_d = COLLECT;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = DIVIDE;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            sum_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            nbit_q  <= 1'b0;
            bcnt_q  <= '0;
            run_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            nbit_q  <= nbit_d;
            bcnt_q  <= bcnt_d;
            run_q   <= run_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[cnt_q] <= softmax_data_in;
    end

    assign softmax_ready_in  = (state_q == COLLECT);
    assign softmax_valid_out = valid_q;
    assign softmax_data_out  = data_q;
    assign softmax_index_out = idx_q;
    assign softmax_last_out  = last_q;

endmodule

// File: tb/tb_softmax_norm.sv
// Directed bench for softmax_norm with NUM_CLASSES=4: values, index/last,
// latency, backpressure, mid-vector reset and back-to-back vectors.
module tb_softmax_norm;

    localparam logic [31:0] ONE = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        softmax_ready_in;
    logic        softmax_valid_in;
    logic [31:0] softmax_data_in;
    logic        softmax_ready_out;
    logic        softmax_valid_out;
    logic [31:0] softmax_data_out;
    logic [1:0]  softmax_index_out;
    logic        softmax_last_out;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_hs = 0;

    softmax_norm #(.DATA_WIDTH(32), .FRACTION(24), .NUM_CLASSES(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .softmax_ready_in  (softmax_ready_in),
        .softmax_valid_in  (softmax_valid_in),
        .softmax_data_in   (softmax_data_in),
        .softmax_ready_out (softmax_ready_out),
        .softmax_valid_out (softmax_valid_out),
        .softmax_data_out  (softmax_data_out),
        .softmax_index_out (softmax_index_out),
        .softmax_last_out  (softmax_last_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send1(input logic [31:0] d);
        int n;
        softmax_valid_in = 1'b1;
        softmax_data_in  = d;
        n = 0;
        while (!softmax_ready_in && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!softmax_ready_in) begin
            chk("in_timeout", 1, 0);
            return;
        end
        @(posedge clk); #1;
        last_hs = cyc;
    endtask

    task automatic send4(input logic [31:0] a, b, c, d);
        send1(a);
        send1(b);
        send1(c);
        send1(d);
        softmax_valid_in = 1'b0;
    endtask

    task automatic recv1(input logic [31:0] e, input int i, input int lat, input int hold);
        int n;
        int nbad;
        softmax_ready_out = (hold == 0);
        n = 0;
        while (!softmax_valid_out && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!softmax_valid_out) begin
            chk($sformatf("out%0d_timeout", i), 0, 1);
            return;
        end
        chk($sformatf("data%0d", i), softmax_data_out, e);
        chk($sformatf("idx%0d", i), softmax_index_out, i);
        chk($sformatf("last%0d", i), softmax_last_out, (i == 3));
        if (lat >= 0) chk($sformatf("lat%0d", i), cyc - last_hs, lat);
        if (hold > 0) begin
            nbad = 0;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                if (softmax_valid_out !== 1'b1 || softmax_data_out !== e ||
                    softmax_index_out !== 2'(i) || softmax_last_out !== (i == 3) ||
                    softmax_ready_in !== 1'b0)
                    nbad++;
            end
            chk("bp_stable", nbad, 0);
            softmax_ready_out = 1'b1;
        end
        @(posedge clk); #1;
        last_hs = cyc;
        chk($sformatf("vld_drop%0d", i), softmax_valid_out, 0);
    endtask

    task automatic recv4(input logic [31:0] e0, e1, e2, e3,
                         input int lat0, input int latn, input int hold_idx);
        logic [31:0] ev [4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        for (int i = 0; i < 4; i++)
            recv1(ev[i], i, (i == 0) ? lat0 : latn, (i == hold_idx) ? 10 : 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        softmax_valid_in  = 1'b0;
        softmax_data_in   = '0;
        softmax_ready_out = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", softmax_valid_out, 0);
        chk("rst_data", softmax_data_out, 0);
        chk("rst_idx", softmax_index_out, 0);
        chk("rst_last", softmax_last_out, 0);
        chk("rst_ready_in", softmax_ready_in, 1);

        // uniform
        send4(ONE, ONE, ONE, ONE);
        recv4(32'h0040_0000, 32'h0040_0000, 32'h0040_0000, 32'h0040_0000, 26, 26, -1);

        // mixed, with backpressure on index 1
        send4(32'h0300_0000, ONE, 0, 0);
        recv4(32'h00C0_0000, 32'h0040_0000, 0, 0, 26, 26, 1);

        // truncation: 1/3
        send4(ONE, ONE, ONE, 0);
        recv4(32'h0055_5555, 32'h0055_5555, 32'h0055_5555, 0, 26, 26, -1);

        // single non-zero element gives exactly 1.0
        send4(0, 0, 32'h0200_0000, 0);
        recv4(0, 0, ONE, 0, 26, 26, -1);

        // all-zero vector skips the divider
        send4(0, 0, 0, 0);
        recv4(0, 0, 0, 0, 2, 2, -1);

        // reset after two inputs discards the partial vector
        send1(32'h0700_0000);
        send1(32'h0500_0000);
        softmax_valid_in = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid", softmax_valid_out, 0);
        chk("mid_rst_ready_in", softmax_ready_in, 1);
        send4(ONE, ONE, ONE, ONE);
        recv4(32'h0040_0000, 32'h0040_0000, 32'h0040_0000, 32'h0040_0000, 26, 26, -1);

        // back-to-back: next vector is presented while the current one drains
        send4(32'h0300_0000, ONE, 0, 0);
        fork
            send4(ONE, ONE, ONE, 0);
            recv4(32'h00C0_0000, 32'h0040_0000, 0, 0, 26, 26, -1);
        join
        recv4(32'h0055_5555, 32'h0055_5555, 32'h0055_5555, 0, 26, 26, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
